// File: rtl/muon_pkg.sv
// ============================================================================
// Module   : muon_pkg
// Purpose  : Shared constants and state encoding for the muon decay-time BCD path.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package muon_pkg;

  localparam int unsigned BCD_DIGIT_W = 4;
  localparam int unsigned N_DIGITS    = 8;
  localparam int unsigned BCD_W       = BCD_DIGIT_W * N_DIGITS;

  // Largest value representable in N_DIGITS decimal digits.
  localparam logic [26:0] BCD_MAX     = 27'd99_999_999;

  // All-nines pattern presented on overflow.
  localparam logic [BCD_W-1:0] BCD_SAT = {N_DIGITS{4'h9}};

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_t;

endpackage : muon_pkg

`default_nettype wire

// File: rtl/bcd_digit_adjust.sv
// ============================================================================
// Module   : bcd_digit_adjust
// Purpose  : Double-dabble nibble correction: adds 3 to any digit of 5 or more.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_digit_adjust
  import muon_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] din,
  output logic [BCD_DIGIT_W-1:0] dout
);

  // Nibbles above 9 only occur for out-of-range inputs; the 4-bit wrap is harmless there.
  assign dout = (din >= BCD_DIGIT_W'(5)) ? din + BCD_DIGIT_W'(3) : din;

endmodule : bcd_digit_adjust

`default_nettype wire

// File: rtl/bin_to_bcd8.sv
// ============================================================================
// Module   : bin_to_bcd8
// Purpose  : Sequential double-dabble converter, binary count to 8 packed BCD digits.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bin_to_bcd8
  import muon_pkg::*;
#(
  parameter int unsigned BIN_W = 27
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [BIN_W-1:0] bin_in,
  output logic             busy,
  output logic             done,
  output logic             overflow,
  output logic [15:0]      digits_A,
  output logic [15:0]      digits_B
);

  localparam int unsigned CNT_W = $clog2(BIN_W + 1);

  state_t             r_state;
  logic [BIN_W-1:0]   r_shift;
  logic [BCD_W-1:0]   r_bcd;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_ovf_pend;

  logic [BCD_W-1:0]   w_bcd_adj;
  logic [BCD_W-1:0]   w_bcd_next;
  logic [BCD_W-1:0]   w_result;
  logic               w_in_ovf;

  genvar gi;
  generate
    for (gi = 0; gi < N_DIGITS; gi++) begin : g_adj
      bcd_digit_adjust u_adj (
        .din  (r_bcd    [gi*BCD_DIGIT_W +: BCD_DIGIT_W]),
        .dout (w_bcd_adj[gi*BCD_DIGIT_W +: BCD_DIGIT_W])
      );
    end
  endgenerate

  // Bit 31 of the adjusted value falls off the top; it can only be set for overflow inputs.
  assign w_bcd_next = {w_bcd_adj[BCD_W-2:0], r_shift[BIN_W-1]};
  assign w_result   = r_ovf_pend ? BCD_SAT : w_bcd_next;
  assign w_in_ovf   = (bin_in > BIN_W'(BCD_MAX));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_shift    <= '0;
      r_bcd      <= '0;
      r_cnt      <= '0;
      r_ovf_pend <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      overflow   <= 1'b0;
      digits_A   <= 16'h0000;
      digits_B   <= 16'h0000;
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_shift    <= bin_in;
            r_bcd      <= '0;
            r_cnt      <= CNT_W'(BIN_W);
            r_ovf_pend <= w_in_ovf;
            busy       <= 1'b1;
            r_state    <= CONV;
          end
        end
        CONV: begin
          r_bcd   <= w_bcd_next;
          r_shift <= {r_shift[BIN_W-2:0], 1'b0};
          r_cnt   <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            digits_A <= w_result[31:16];
            digits_B <= w_result[15:0];
            overflow <= r_ovf_pend;
            done     <= 1'b1;
            busy     <= 1'b0;
            r_state  <= IDLE;
          end
        end
        default: begin
          busy    <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule : bin_to_bcd8

`default_nettype wire

// File: tb/tb_bin_to_bcd8.sv
// ============================================================================
// Module   : tb_bin_to_bcd8
// Purpose  : Directed-vector self-checking bench for bin_to_bcd8.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bin_to_bcd8;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [26:0] bin_in;
  logic        busy;
  logic        done;
  logic        overflow;
  logic [15:0] digits_A;
  logic [15:0] digits_B;

  int n_tests = 0;
  int n_fail  = 0;

  bin_to_bcd8 #(.BIN_W(27)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .bin_in   (bin_in),
    .busy     (busy),
    .done     (done),
    .overflow (overflow),
    .digits_A (digits_A),
    .digits_B (digits_B)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Pulse start for one edge, then wait (bounded) for done; lat = edges after the start edge.
  task automatic run_conv(input logic [26:0] v, output int lat);
    @(negedge clk);
    start  = 1'b1;
    bin_in = v;
    @(posedge clk); #1;
    start  = 1'b0;
    bin_in = 27'h5A5A5A5;
    check("busy_after_start", {31'd0, busy}, 32'd1);
    lat = 0;
    while (!done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  int lat;
  int res;
  int cyc;
  int last_done;
  int bad;
  logic [31:0] exp_vals [3];
  logic [26:0] in_vals  [3];

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    bin_in = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_ovf",  {31'd0, overflow}, 32'd0);
    check("rst_digits", {digits_A, digits_B}, 32'h0000_0000);
    @(negedge clk);
    rst = 1'b0;

    // T1
    run_conv(27'd71_154_937, lat);
    check("t1_lat", lat, 27);
    check("t1_busy_done", {30'd0, busy, done}, 32'd1);
    check("t1_digits", {digits_A, digits_B}, 32'h7115_4937);
    check("t1_ovf", {31'd0, overflow}, 32'd0);
    @(posedge clk); #1;
    check("t1_done_pulse", {31'd0, done}, 32'd0);
    check("t1_hold", {digits_A, digits_B}, 32'h7115_4937);

    // T2
    run_conv(27'd0, lat);
    check("t2_zero", {digits_A, digits_B}, 32'h0000_0000);
    run_conv(27'd99_999_999, lat);
    check("t2_max", {digits_A, digits_B}, 32'h9999_9999);
    check("t2_max_ovf", {31'd0, overflow}, 32'd0);

    // T3
    run_conv(27'd100_000_000, lat);
    check("t3_lat", lat, 27);
    check("t3_sat", {digits_A, digits_B}, 32'h9999_9999);
    check("t3_ovf", {31'd0, overflow}, 32'd1);
    run_conv(27'd42, lat);
    check("t3_42", {digits_A, digits_B}, 32'h0000_0042);
    check("t3_42_ovf", {31'd0, overflow}, 32'd0);

    // T4: start held high, bin_in scrambled except in done cycles
    in_vals[0] = 27'd11_111_111; exp_vals[0] = 32'h1111_1111;
    in_vals[1] = 27'd20_230_517; exp_vals[1] = 32'h2023_0517;
    in_vals[2] = 27'd98_765_432; exp_vals[2] = 32'h9876_5432;
    @(negedge clk);
    start = 1'b1;
    bin_in = in_vals[0];
    res = 0; cyc = 0; last_done = -1; bad = 0;
    while (res < 3 && cyc < 200) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (busy === done) bad++;
      if (done) begin
        check("t4_digits", {digits_A, digits_B}, exp_vals[res]);
        if (last_done >= 0) check("t4_period", cyc - last_done, 28);
        last_done = cyc;
        res++;
        if (res < 3) bin_in = in_vals[res];
        else start = 1'b0;
      end else begin
        bin_in = 27'($urandom);
      end
    end
    start = 1'b0;
    check("t4_count", res, 3);
    check("t4_busy_vs_done", bad, 0);

    // T5: reset 10 cycles into a conversion
    @(negedge clk);
    start = 1'b1;
    bin_in = 27'd55_555_555;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("t5_rst_digits", {digits_A, digits_B}, 32'h0000_0000);
    check("t5_rst_busy", {30'd0, busy, overflow}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (done || busy) bad++;
    end
    check("t5_no_done", bad, 0);
    run_conv(27'd3, lat);
    check("t5_fresh", {digits_A, digits_B}, 32'h0000_0003);
    check("t5_fresh_lat", lat, 27);

    // T6: restart in the done cycle
    run_conv(27'd12_345_678, lat);
    check("t6_first", {digits_A, digits_B}, 32'h1234_5678);
    @(negedge clk);
    start = 1'b1;
    bin_in = 27'd87_654_321;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1; bad = 0;
    while (!done && lat < 40) begin
      if ({digits_A, digits_B} !== 32'h1234_5678) bad++;
      @(posedge clk); #1;
      lat++;
    end
    check("t6_period", lat, 28);
    check("t6_hold", bad, 0);
    check("t6_second", {digits_A, digits_B}, 32'h8765_4321);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_bin_to_bcd8

`default_nettype wire
